ofdm_tx_framer: RTL and testbench

- Transmit-side counterpart of the receiver's short/long synchronisation chain.
- Builds one 802.11a-style time-domain frame in this order: 160-sample short preamble, 32-sample long CP, two 64-sample long training symbols (T1, T2), then `num_symbols` data symbols of 64 IFFT samples, each preceded by its 16-sample cyclic prefix.
- Sits between the IFFT output and the DAC/interpolator.
- Preamble samples come from an external 1-cycle-latency ROM. Data symbols go through an internal ping-pong 2x64 buffer so the CP can be inserted.

---
 rtl/ofdm_tx_framer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ofdm_tx_framer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_tx_framer.sv
// rtl/ofdm_tx_framer.sv - 802.11a-style transmit framer: ROM preamble, ping-pong data symbols with CP
module ofdm_tx_framer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NSYM_WIDTH  = 8,
  parameter int SHORT_LEN   = 160,
  parameter int LONG_CP_LEN = 32,
  parameter int FFT_LEN     = 64,
  parameter int CP_LEN      = 16
) (
  input  logic                  CLK,
  input  logic                  s_RST,
  input  logic                  start,
  input  logic [NSYM_WIDTH-1:0] num_symbols,
  input  logic                  sample_tick,
  input  logic                  in_strobe,
  input  logic [DATA_WIDTH-1:0] in_I,
  input  logic [DATA_WIDTH-1:0] in_Q,
  output logic                  in_ready,
  output logic [6:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_I,
  input  logic [DATA_WIDTH-1:0] rom_Q,
  output logic                  Out_Strobe,
  output logic [DATA_WIDTH-1:0] out_I,
  output logic [DATA_WIDTH-1:0] out_Q,
  output logic                  Providing_Preamble,
  output logic                  Providing_Stream,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int IW = $clog2(FFT_LEN);
  localparam int CW = $clog2(SHORT_LEN + 1);
  localparam int SW = 2 * DATA_WIDTH;
  // ROM layout: words 0..15 one short period, words 16..79 the long symbol
  localparam logic [6:0]    ROM_LONG_BASE = 7'd16;
  localparam logic [6:0]    ROM_LCP_BASE  = 7'(16 + FFT_LEN - LONG_CP_LEN);
  localparam logic [IW-1:0] CP_BASE       = IW'(FFT_LEN - CP_LEN);

  typedef enum logic [3:0] {
    IDLE, SHORT, LONG_CP, LONG1, LONG2, SYM_WAIT, SYM_CP, SYM_DATA, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NSYM_WIDTH-1:0] nsym_q, nsym_d;
  logic [NSYM_WIDTH-1:0] emit_q, emit_d;
  logic [NSYM_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [NSYM_WIDTH-1:0] emit_inc;
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  strobe_q, strobe_d;
  logic                  pre_q, pre_d;
  logic                  stream_q, stream_d;
  logic [6:0]            rom_addr_q, rom_addr_d;
  logic [SW-1:0]         hold_q;
  logic [SW-1:0]         rd_data_q;
  logic [SW-1:0]         cur_sample;
  logic                  rd_en;
  logic [IW-1:0]         rd_idx;
  logic                  wr_fire;

  logic [SW-1:0] mem [0:2*FFT_LEN-1];

  assign in_ready = busy_q & ~bank_full_q[wr_bank_q] & (wr_cnt_q < nsym_q) & (state_q != DONE);
  assign wr_fire  = in_strobe & in_ready;
  assign emit_inc = emit_q + NSYM_WIDTH'(1);

  // ROM data arrives one cycle after its address, so a preamble sample is taken straight
  // from rom_I/rom_Q in the strobe cycle; between strobes the last sample is held.
  assign cur_sample = pre_q ? {rom_I, rom_Q} : rd_data_q;
  assign {out_I, out_Q} = strobe_q ? cur_sample : hold_q;

  assign rom_addr           = rom_addr_q;
  assign Out_Strobe         = strobe_q;
  assign Providing_Preamble = strobe_q & pre_q;
  assign Providing_Stream   = strobe_q & stream_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;
  assign underrun           = underrun_q;

  // Next-state logic: frame sequencer, ping-pong writer and reader bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nsym_d      = nsym_q;
    emit_d      = emit_q;
    wr_cnt_d    = wr_cnt_q;
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    strobe_d    = 1'b0;
    pre_d       = 1'b0;
    stream_d    = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = '0;
    rom_addr_d  = '0;

    if (wr_fire) begin
      wr_idx_d = wr_idx_q + IW'(1);
      if (wr_idx_q == IW'(FFT_LEN - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_cnt_d               = wr_cnt_q + NSYM_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          nsym_d     = num_symbols;
          underrun_d = 1'b0;
          busy_d     = 1'b1;
          emit_d     = '0;
          wr_cnt_d   = '0;
          cnt_d      = '0;
          state_d    = SHORT;
        end
      end
      SHORT: begin
        if (sample_tick) begin
          strobe_d = 1'b1;
          pre_d    = 1'b1;
          if (cnt_q == CW'(SHORT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = LONG_CP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LONG_CP: begin
        if (sample_tick) begin
          strobe_d = 1'b1;
          pre_d    = 1'b1;
          if (cnt_q == CW'(LONG_CP_LEN - 1)) begin
            cnt_d   = '0;
            state_d = LONG1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LONG1, LONG2: begin
        if (sample_tick) begin
          strobe_d = 1'b1;
          pre_d    = 1'b1;
          if (cnt_q == CW'(FFT_LEN - 1)) begin
            cnt_d = '0;
            if (state_q == LONG1)     state_d = LONG2;
            else if (nsym_q == '0)    state_d = DONE;
            else                      state_d = SYM_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SYM_WAIT: begin
        // Entering SYM_CP costs no tick: a tick arriving with the bank ready is the first CP sample.
        if (bank_full_q[rd_bank_q]) begin
          state_d = SYM_CP;
          cnt_d   = '0;
          if (sample_tick) begin
            strobe_d = 1'b1;
            stream_d = 1'b1;
            rd_en    = 1'b1;
            rd_idx   = CP_BASE;
            cnt_d    = CW'(1);
          end
        end else if (sample_tick) begin
          underrun_d = 1'b1;
        end
      end
      SYM_CP: begin
        if (sample_tick) begin
          strobe_d = 1'b1;
          stream_d = 1'b1;
          rd_en    = 1'b1;
          rd_idx   = CP_BASE + IW'(cnt_q);
          if (cnt_q == CW'(CP_LEN - 1)) begin
            cnt_d   = '0;
            state_d = SYM_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SYM_DATA: begin
        if (sample_tick) begin
          strobe_d = 1'b1;
          stream_d = 1'b1;
          rd_en    = 1'b1;
          rd_idx   = IW'(cnt_q);
          if (cnt_q == CW'(FFT_LEN - 1)) begin
            cnt_d                  = '0;
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            emit_d                 = emit_inc;
            state_d                = (emit_inc == nsym_q) ? DONE : SYM_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        bank_full_d = '0;
        wr_bank_d   = 1'b0;
        rd_bank_d   = 1'b0;
        wr_idx_d    = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address is registered from the next state so it is already valid in the tick cycle
    case (state_d)
      SHORT:        rom_addr_d = {3'b000, cnt_d[3:0]};
      LONG_CP:      rom_addr_d = ROM_LCP_BASE + 7'(cnt_d);
      LONG1, LONG2: rom_addr_d = ROM_LONG_BASE + 7'(cnt_d);
      default:      rom_addr_d = '0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (s_RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nsym_q      <= '0;
      emit_q      <= '0;
      wr_cnt_q    <= '0;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      strobe_q    <= 1'b0;
      pre_q       <= 1'b0;
      stream_q    <= 1'b0;
      rom_addr_q  <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nsym_q      <= nsym_d;
      emit_q      <= emit_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      strobe_q    <= strobe_d;
      pre_q       <= pre_d;
      stream_q    <= stream_d;
      rom_addr_q  <= rom_addr_d;
      if (strobe_q) hold_q <= cur_sample;
    end
  end

  // Ping-pong symbol buffer: bank bit on top of the 6-bit sample index
  always_ff @(posedge CLK) begin
    if (wr_fire) mem[{wr_bank_q, wr_idx_q}] <= {in_I, in_Q};
    if (rd_en)   rd_data_q <= mem[{rd_bank_q, rd_idx}];
  end

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// tb/tb_ofdm_tx_framer.sv - directed self-checking bench for ofdm_tx_framer
module tb_ofdm_tx_framer;

  logic        CLK = 1'b0;
  logic        s_RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_symbols = '0;
  logic        sample_tick = 1'b0;
  logic        in_strobe = 1'b0;
  logic [15:0] in_I = '0, in_Q = '0;
  logic        in_ready;
  logic [6:0]  rom_addr;
  logic [15:0] rom_I = '0, rom_Q = '0;
  logic        Out_Strobe, Providing_Preamble, Providing_Stream, busy, frame_done, underrun;
  logic [15:0] out_I, out_Q;

  always #5 CLK = ~CLK;

  ofdm_tx_framer dut (
    .CLK(CLK), .s_RST(s_RST), .start(start), .num_symbols(num_symbols),
    .sample_tick(sample_tick), .in_strobe(in_strobe), .in_I(in_I), .in_Q(in_Q),
    .in_ready(in_ready), .rom_addr(rom_addr), .rom_I(rom_I), .rom_Q(rom_Q),
    .Out_Strobe(Out_Strobe), .out_I(out_I), .out_Q(out_Q),
    .Providing_Preamble(Providing_Preamble), .Providing_Stream(Providing_Stream),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  // Preamble ROM model, one cycle latency; word contents encode the address
  always @(posedge CLK) begin
    rom_I <= 16'h4000 | 16'(rom_addr);
    rom_Q <= 16'h8000 | 16'(rom_addr);
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc, n_strobe, n_bad, n_late, first_bad;
  int first_cyc, last_cyc, done_cyc, pre_end_cyc, sym_cyc, ur_cyc, fill_cyc;
  int tick_period, feed_start, feed_total, feed_idx, restart_cyc, base;
  logic tick_en, ready_prev, busy_prev, busy_at_done, busy_before, ready_at_fill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sym_val(int s, int j);
    return 16'(base + s * 100 + j);
  endfunction

  // Expected {preamble flag, stream flag, I, Q} for the n-th strobe of a frame
  function automatic logic [33:0] exp_sample(int n);
    int a, m, r, idx;
    logic [15:0] v;
    if (n < 320) begin
      if (n < 160)      a = n % 16;
      else if (n < 192) a = 48 + n - 160;
      else if (n < 256) a = 16 + n - 192;
      else              a = 16 + n - 256;
      return {2'b10, 16'h4000 | 16'(a), 16'h8000 | 16'(a)};
    end
    m   = n - 320;
    r   = m % 80;
    idx = (r < 16) ? 48 + r : r - 16;
    v   = sym_val(m / 80, idx);
    return {2'b01, v, ~v};
  endfunction

  task automatic step();
    logic [33:0] e;
    @(posedge CLK);
    #1;
    cyc++;
    if (in_strobe && ready_prev) begin
      feed_idx++;
      if (feed_idx == feed_total) begin
        fill_cyc      = cyc;
        ready_at_fill = in_ready;
      end
    end
    if (Out_Strobe) begin
      e = exp_sample(n_strobe);
      if ({Providing_Preamble, Providing_Stream, out_I, out_Q} !== e) begin
        if (n_bad == 0) first_bad = n_strobe;
        n_bad++;
      end
      if (!sample_tick) n_late++;
      if (n_strobe == 0)   first_cyc = cyc;
      if (n_strobe == 319) pre_end_cyc = cyc;
      if (n_strobe == 320) sym_cyc = cyc;
      n_strobe++;
      last_cyc = cyc;
    end
    if (frame_done && done_cyc < 0) begin
      done_cyc     = cyc;
      busy_at_done = busy;
      busy_before  = busy_prev;
    end
    if (underrun && ur_cyc < 0) ur_cyc = cyc;
    busy_prev   = busy;
    start       = (cyc == restart_cyc);
    if (cyc == restart_cyc) num_symbols = 8'd5;
    sample_tick = tick_en && (cyc % tick_period == 0);
    in_strobe   = (cyc >= feed_start) && (feed_idx < feed_total);
    in_I        = sym_val(feed_idx / 64, feed_idx % 64);
    in_Q        = ~in_I;
    ready_prev  = in_ready;
  endtask

  task automatic run_frame(input int nsym, input int period, input int fstart,
                           input int ftotal, input int stop_n, input int restart);
    cyc = 0; n_strobe = 0; n_bad = 0; n_late = 0; first_bad = -1;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; pre_end_cyc = -1;
    sym_cyc = -1; ur_cyc = -1; fill_cyc = -1; feed_idx = 0;
    busy_prev = 1'b0; ready_prev = 1'b0; ready_at_fill = 1'b1;
    tick_period = period; feed_start = fstart; feed_total = ftotal;
    restart_cyc = restart; tick_en = 1'b1;
    num_symbols = 8'(nsym); start = 1'b1; sample_tick = 1'b0; in_strobe = 1'b0;
    while (done_cyc < 0 && n_strobe < stop_n && cyc < 3000) step();
    tick_en = 1'b0; sample_tick = 1'b0; in_strobe = 1'b0; start = 1'b0;
  endtask

  initial begin
    base = 0; tick_period = 1; tick_en = 1'b0; restart_cyc = -1;
    feed_start = 0; feed_total = 0; feed_idx = 0; cyc = 0;
    s_RST = 1'b1;
    step(); step();
    check("rst_flags", {in_ready, Out_Strobe, Providing_Preamble, Providing_Stream, busy, frame_done, underrun}, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_out", {out_I, out_Q}, 0);
    s_RST = 1'b0;
    step();

    // Preamble-only frame
    run_frame(0, 1, 0, 0, 9999, -1);
    check("t1_done_seen", done_cyc >= 0, 1);
    check("t1_strobes", n_strobe, 320);
    check("t1_bad_samples", n_bad, 0);
    check("t1_done_lag", done_cyc - last_cyc, 1);
    check("t1_busy_at_done", busy_at_done, 0);
    check("t1_busy_before", busy_before, 1);
    step(); step();

    // Two preloaded ramp symbols, continuous ticks
    run_frame(2, 1, 0, 128, 9999, -1);
    check("t2_done_seen", done_cyc >= 0, 1);
    check("t2_strobes", n_strobe, 480);
    check("t2_bad_samples", n_bad, 0);
    check("t2_first_bad", first_bad, -1);
    check("t2_underrun", underrun, 0);
    check("t2_no_gaps", last_cyc - first_cyc, 479);
    check("t2_done_lag", done_cyc - last_cyc, 1);
    step(); step();

    // IFFT late: SYM_WAIT underrun, CP starts right after the 64th write
    run_frame(1, 1, 400, 64, 9999, -1);
    check("t3_done_seen", done_cyc >= 0, 1);
    check("t3_strobes", n_strobe, 400);
    check("t3_bad_samples", n_bad, 0);
    check("t3_underrun_lag", ur_cyc - pre_end_cyc, 1);
    check("t3_cp_after_fill", sym_cyc - fill_cyc, 1);
    check("t3_ready_after_fill", ready_at_fill, 0);
    check("t3_underrun_sticky", underrun, 1);
    step(); step();

    // Tick every third cycle
    run_frame(2, 3, 0, 128, 9999, -1);
    check("t4_done_seen", done_cyc >= 0, 1);
    check("t4_strobes", n_strobe, 480);
    check("t4_bad_samples", n_bad, 0);
    check("t4_strobe_without_tick", n_late, 0);
    check("t4_spacing", last_cyc - first_cyc, 3 * 479);
    check("t4_underrun_cleared", underrun, 0);
    step(); step();

    // Reset in SYM_DATA, then a fresh one-symbol frame with new data
    run_frame(2, 1, 0, 128, 346, -1);
    check("t5_reached_sym_data", n_strobe, 346);
    check("t5_pre_reset_bad", n_bad, 0);
    s_RST = 1'b1;
    tick_en = 1'b1;
    step();
    check("t5_rst_flags", {in_ready, Out_Strobe, Providing_Preamble, Providing_Stream, busy, frame_done, underrun}, 0);
    check("t5_rst_rom_addr", rom_addr, 0);
    check("t5_rst_out", {out_I, out_Q}, 0);
    s_RST = 1'b0;
    tick_en = 1'b0;
    step();
    base = 1000;
    run_frame(1, 1, 0, 64, 9999, -1);
    check("t5_done_seen", done_cyc >= 0, 1);
    check("t5_strobes", n_strobe, 400);
    check("t5_bad_samples", n_bad, 0);
    check("t5_underrun", underrun, 0);
    base = 0;
    step(); step();

    // Start pulse while busy is ignored
    run_frame(0, 1, 0, 0, 9999, 50);
    check("t6_done_seen", done_cyc >= 0, 1);
    check("t6_strobes", n_strobe, 320);
    check("t6_bad_samples", n_bad, 0);
    check("t6_done_lag", done_cyc - last_cyc, 1);
    step(); step();
    check("t6_idle_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
